// File: rtl/tsn_pkt_pkg.sv
// Flit format shared by the PCB datapath: 134-bit flits, 2-bit header in the
// top bits, 16-bit RAM addresses.
package tsn_pkt_pkg;

  localparam int FLIT_W = 134;
  localparam int ADDR_W = 16;
  localparam int HDR_HI = 133;
  localparam int HDR_LO = 132;

  typedef enum logic [1:0] {
    HDR_BODY   = 2'b00,
    HDR_HEAD   = 2'b01,
    HDR_TAIL   = 2'b10,
    HDR_SINGLE = 2'b11
  } hdr_e;

  // A flit may legally start a packet only if it carries head or single-flit bits.
  function automatic logic hdr_opens(input logic [1:0] hdr);
    return (hdr == HDR_HEAD) || (hdr == HDR_SINGLE);
  endfunction

  function automatic logic hdr_closes(input logic [1:0] hdr);
    return (hdr == HDR_TAIL) || (hdr == HDR_SINGLE);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: scans req_i starting at ptr_i,
// wrapping modulo N, and reports the first set index.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic         hit_o,
  output logic [2:0]   idx_o
);

  always_comb begin
    int k;
    k     = 0;
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      if (!hit_o && req_i[k]) begin
        hit_o = 1'b1;
        idx_o = 3'(k);
      end
    end
  end

endmodule

// File: rtl/pcb_write_arbiter.sv
// Packet-granular round-robin arbiter sharing the PCB RAM write port among N
// flit writers, relaying each flit's write/ack handshake and guarding stalled locks.
module pcb_write_arbiter
  import tsn_pkt_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N-1:0]          iv_wr,
  input  logic [N*FLIT_W-1:0]   iv_wdata,
  input  logic [N*ADDR_W-1:0]   iv_waddr,
  output logic [N-1:0]          ov_ack,
  output logic [FLIT_W-1:0]     ov_wdata,
  output logic                  o_data_wr,
  output logic [ADDR_W-1:0]     ov_data_waddr,
  input  logic                  i_wdata_ack,
  output logic [2:0]            ov_grant_id,
  output logic                  o_busy,
  output logic [CW-1:0]         ov_timeout_cnt,
  output logic [CW-1:0]         ov_nohead_cnt
);

  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_RELAY
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [2:0]          rr_q, rr_d;
  logic                busy_q, busy_d;
  logic                data_wr_q, data_wr_d;
  logic [FLIT_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [N-1:0]        ack_q, ack_d;
  logic [WDW-1:0]      wdog_q, wdog_d;
  logic [CW-1:0]       tocnt_q, tocnt_d;
  logic [CW-1:0]       nohead_q, nohead_d;

  logic                pick_hit;
  logic [2:0]          pick_idx;
  logic [2:0]          sel_idx;
  logic [2:0]          next_ptr;
  logic                wr_sel;
  logic [FLIT_W-1:0]   wdata_sel;
  logic [ADDR_W-1:0]   waddr_sel;

  rr_pick #(.N(N)) u_rr_pick (
    .req_i (iv_wr),
    .ptr_i (rr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  // In IDLE the candidate is the one being granted this cycle; afterwards it is the owner.
  assign sel_idx  = (state_q == ST_IDLE) ? pick_idx : grant_q;
  assign next_ptr = (grant_q == 3'(N - 1)) ? 3'd0 : grant_q + 3'd1;

  always_comb begin
    wr_sel    = 1'b0;
    wdata_sel = '0;
    waddr_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_idx == 3'(k)) begin
        wr_sel    = iv_wr[k];
        wdata_sel = iv_wdata[k*FLIT_W +: FLIT_W];
        waddr_sel = iv_waddr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    busy_d    = busy_q;
    data_wr_d = data_wr_q;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    ack_d     = '0;
    wdog_d    = wdog_q;
    tocnt_d   = tocnt_q;
    nohead_d  = nohead_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_hit) begin
          grant_d = pick_idx;
          busy_d  = 1'b1;
          wdog_d  = '0;
          state_d = ST_ISSUE;
          if (!hdr_opens(wdata_sel[HDR_HI:HDR_LO]) && (nohead_q != '1))
            nohead_d = nohead_q + CW'(1);
        end
      end

      ST_ISSUE: begin
        if (wr_sel) begin
          wdata_d   = wdata_sel;
          waddr_d   = waddr_sel;
          data_wr_d = 1'b1;
          wdog_d    = '0;
          state_d   = ST_WAIT_ACK;
        end else if (wdog_q == WDW'(TIMEOUT)) begin
          busy_d  = 1'b0;
          rr_d    = next_ptr;
          wdog_d  = '0;
          state_d = ST_IDLE;
          if (tocnt_q != '1)
            tocnt_d = tocnt_q + CW'(1);
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      ST_WAIT_ACK: begin
        if (i_wdata_ack) begin
          data_wr_d = 1'b0;
          for (int k = 0; k < N; k++)
            ack_d[k] = (grant_q == 3'(k));
          state_d = ST_RELAY;
        end
      end

      // The requester still presents the acked flit here, so iv_wr is not looked at.
      ST_RELAY: begin
        if (hdr_closes(wdata_q[HDR_HI:HDR_LO])) begin
          busy_d  = 1'b0;
          rr_d    = next_ptr;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      busy_q    <= 1'b0;
      data_wr_q <= 1'b0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      ack_q     <= '0;
      wdog_q    <= '0;
      tocnt_q   <= '0;
      nohead_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      busy_q    <= busy_d;
      data_wr_q <= data_wr_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      ack_q     <= ack_d;
      wdog_q    <= wdog_d;
      tocnt_q   <= tocnt_d;
      nohead_q  <= nohead_d;
    end
  end

  assign ov_ack         = ack_q;
  assign ov_wdata       = wdata_q;
  assign o_data_wr      = data_wr_q;
  assign ov_data_waddr  = waddr_q;
  assign ov_grant_id    = grant_q;
  assign o_busy         = busy_q;
  assign ov_timeout_cnt = tocnt_q;
  assign ov_nohead_cnt  = nohead_q;

endmodule

// File: tb/tb_pcb_write_arbiter.sv
// Directed bench for pcb_write_arbiter: the bench plays the requesters and the
// RAM, and compares against hand-computed grant orders, flits and counters.
module tb_pcb_write_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 255;
  localparam int CW      = 8;
  localparam int FW      = 134;
  localparam int AW      = 16;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [N-1:0]    iv_wr;
  logic [N*FW-1:0] iv_wdata;
  logic [N*AW-1:0] iv_waddr;
  logic            i_wdata_ack;
  logic [N-1:0]    ov_ack;
  logic [FW-1:0]   ov_wdata;
  logic            o_data_wr;
  logic [AW-1:0]   ov_data_waddr;
  logic [2:0]      ov_grant_id;
  logic            o_busy;
  logic [CW-1:0]   ov_timeout_cnt;
  logic [CW-1:0]   ov_nohead_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pcb_write_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .iv_wr          (iv_wr),
    .iv_wdata       (iv_wdata),
    .iv_waddr       (iv_waddr),
    .ov_ack         (ov_ack),
    .ov_wdata       (ov_wdata),
    .o_data_wr      (o_data_wr),
    .ov_data_waddr  (ov_data_waddr),
    .i_wdata_ack    (i_wdata_ack),
    .ov_grant_id    (ov_grant_id),
    .o_busy         (o_busy),
    .ov_timeout_cnt (ov_timeout_cnt),
    .ov_nohead_cnt  (ov_nohead_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [FW-1:0] mk_flit(input logic [1:0] hdr, input int k, input logic [AW-1:0] addr);
    return {hdr, 4'(k), addr, {7{addr}}};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic wr, input logic [1:0] hdr, input logic [AW-1:0] addr);
    iv_wr[k]              = wr;
    iv_wdata[k*FW +: FW]  = mk_flit(hdr, k, addr);
    iv_waddr[k*AW +: AW]  = addr;
  endtask

  task automatic apply_reset();
    i_rst_n     = 1'b0;
    iv_wr       = '0;
    iv_wdata    = '0;
    iv_waddr    = '0;
    i_wdata_ack = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  // Acts as the RAM: waits (bounded) for a strobe, optionally delays, acks, and
  // returns what was seen including the requester ack vector of the next cycle.
  task automatic serve_flit(input int ack_delay, output logic got, output int lat,
                            output logic [FW-1:0] d, output logic [AW-1:0] a,
                            output logic [2:0] g, output logic [N-1:0] ackv);
    got = 1'b0; lat = 0; d = '0; a = '0; g = '0; ackv = '0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick();
      if (o_data_wr === 1'b1) begin
        got = 1'b1;
        lat = c;
      end
    end
    if (got) begin
      for (int j = 0; j < ack_delay; j++) tick();
      if (o_data_wr !== 1'b1) got = 1'b0;
      d = ov_wdata;
      a = ov_data_waddr;
      g = ov_grant_id;
      i_wdata_ack = 1'b1;
      tick();
      ackv = ov_ack;
      i_wdata_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ov_ack, o_data_wr, ov_data_waddr, ov_grant_id, o_busy, ov_timeout_cnt, ov_nohead_cnt} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got ack=%b wr=%b addr=%h gid=%0d busy=%b to=%0d nh=%0d, required all 0",
               ov_ack, o_data_wr, ov_data_waddr, ov_grant_id, o_busy, ov_timeout_cnt, ov_nohead_cnt);
    end
    n_checks++;
    if (ov_wdata !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_wdata: got %h, required 0", ov_wdata);
    end
  endtask

  task automatic test_single_packet();
    logic [1:0]    hdrs [3] = '{2'b01, 2'b00, 2'b10};
    logic          got;
    int            lat;
    logic [FW-1:0] d;
    logic [AW-1:0] a;
    logic [2:0]    g;
    logic [N-1:0]  ackv;
    $display("[TB] single 3-flit packet on requester 1");
    for (int f = 0; f < 3; f++) begin
      set_req(1, 1'b1, hdrs[f], 16'h0100 + 16'(f));
      serve_flit(1, got, lat, d, a, g, ackv);
      n_checks++;
      if (got !== 1'b1 || d !== mk_flit(hdrs[f], 1, 16'h0100 + 16'(f))) begin
        n_fail++;
        $display("[TB] FAIL sp_flit%0d: got strobe=%b data=%h, required strobe=1 data=%h", f, got, d, mk_flit(hdrs[f], 1, 16'h0100 + 16'(f)));
      end
      n_checks++;
      if (a !== 16'h0100 + 16'(f) || g !== 3'd1 || ackv !== 4'b0010) begin
        n_fail++;
        $display("[TB] FAIL sp_addr_ack%0d: got addr=%h gid=%0d ack=%b, required addr=%h gid=1 ack=0010", f, a, g, ackv, 16'h0100 + 16'(f));
      end
      if (f == 0) begin
        n_checks++;
        if (lat !== 2) begin
          n_fail++;
          $display("[TB] FAIL sp_latency: got %0d cycles, required 2", lat);
        end
      end
    end
    iv_wr[1] = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sp_busy_in_relay: got %b, required 1", o_busy);
    end
    tick();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sp_busy_release: got %b, required 0", o_busy);
    end
    // rr now points at 2: with 0 and 2 both asking, 2 must win first.
    set_req(0, 1'b1, 2'b11, 16'h0200);
    set_req(2, 1'b1, 2'b11, 16'h0220);
    serve_flit(0, got, lat, d, a, g, ackv);
    iv_wr[2] = 1'b0;
    n_checks++;
    if (got !== 1'b1 || g !== 3'd2 || a !== 16'h0220) begin
      n_fail++;
      $display("[TB] FAIL sp_rr_after: got strobe=%b gid=%0d addr=%h, required strobe=1 gid=2 addr=0220", got, g, a);
    end
    serve_flit(0, got, lat, d, a, g, ackv);
    iv_wr[0] = 1'b0;
    n_checks++;
    if (got !== 1'b1 || g !== 3'd0 || a !== 16'h0200) begin
      n_fail++;
      $display("[TB] FAIL sp_rr_next: got strobe=%b gid=%0d addr=%h, required strobe=1 gid=0 addr=0200", got, g, a);
    end
    tick();
  endtask

  task automatic test_two_requesters();
    int            exp_g [4] = '{0, 0, 2, 2};
    logic [1:0]    exp_h [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [AW-1:0] exp_a [4] = '{16'h0300, 16'h0301, 16'h0320, 16'h0321};
    int            ord   [4] = '{3, 0, 1, 2};
    logic          got;
    int            lat;
    logic [FW-1:0] d;
    logic [AW-1:0] a;
    logic [2:0]    g;
    logic [N-1:0]  ackv;
    $display("[TB] requesters 0 and 2 together, then all four");
    apply_reset();
    set_req(0, 1'b1, 2'b01, 16'h0300);
    set_req(2, 1'b1, 2'b01, 16'h0320);
    for (int i = 0; i < 4; i++) begin
      serve_flit(0, got, lat, d, a, g, ackv);
      n_checks++;
      if (got !== 1'b1 || g !== 3'(exp_g[i]) || d !== mk_flit(exp_h[i], exp_g[i], exp_a[i]) || ackv !== (4'b0001 << exp_g[i])) begin
        n_fail++;
        $display("[TB] FAIL two_req_flit%0d: got strobe=%b gid=%0d ack=%b data=%h, required gid=%0d ack=%b data=%h",
                 i, got, g, ackv, d, exp_g[i], 4'b0001 << exp_g[i], mk_flit(exp_h[i], exp_g[i], exp_a[i]));
      end
      if (exp_h[i] == 2'b01) set_req(exp_g[i], 1'b1, 2'b10, exp_a[i] + 16'd1);
      else iv_wr[exp_g[i]] = 1'b0;
    end
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 2'b11, 16'h0400 + 16'(k * 16));
    for (int i = 0; i < 4; i++) begin
      serve_flit(0, got, lat, d, a, g, ackv);
      n_checks++;
      if (got !== 1'b1 || g !== 3'(ord[i]) || a !== 16'h0400 + 16'(ord[i] * 16)) begin
        n_fail++;
        $display("[TB] FAIL all_req_order%0d: got strobe=%b gid=%0d addr=%h, required gid=%0d addr=%h",
                 i, got, g, a, ord[i], 16'h0400 + 16'(ord[i] * 16));
      end
      iv_wr[ord[i]] = 1'b0;
    end
    tick();
  endtask

  task automatic test_single_flit();
    logic          got;
    int            lat;
    logic [FW-1:0] d;
    logic [AW-1:0] a;
    logic [2:0]    g;
    logic [N-1:0]  ackv;
    $display("[TB] single-flit packet on requester 3");
    apply_reset();
    set_req(3, 1'b1, 2'b11, 16'h0500);
    serve_flit(0, got, lat, d, a, g, ackv);
    iv_wr[3] = 1'b0;
    n_checks++;
    if (got !== 1'b1 || g !== 3'd3 || ackv !== 4'b1000 || d !== mk_flit(2'b11, 3, 16'h0500)) begin
      n_fail++;
      $display("[TB] FAIL sf_write: got strobe=%b gid=%0d ack=%b data=%h, required gid=3 ack=1000 data=%h",
               got, g, ackv, d, mk_flit(2'b11, 3, 16'h0500));
    end
    tick();
    n_checks++;
    if (o_busy !== 1'b0 || ov_nohead_cnt !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL sf_release: got busy=%b nohead=%0d, required busy=0 nohead=0", o_busy, ov_nohead_cnt);
    end
  endtask

  task automatic test_timeout();
    logic          got;
    int            lat;
    logic [FW-1:0] d;
    logic [AW-1:0] a;
    logic [2:0]    g;
    logic [N-1:0]  ackv;
    $display("[TB] stalled lock released by watchdog");
    apply_reset();
    set_req(0, 1'b1, 2'b01, 16'h0600);
    set_req(1, 1'b1, 2'b11, 16'h0610);
    serve_flit(0, got, lat, d, a, g, ackv);
    iv_wr[0] = 1'b0;
    n_checks++;
    if (got !== 1'b1 || g !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL to_head: got strobe=%b gid=%0d, required strobe=1 gid=0", got, g);
    end
    // One tick leaves RELAY, then TIMEOUT stalled ISSUE cycles keep the lock.
    for (int c = 0; c < TIMEOUT + 1; c++) tick();
    n_checks++;
    if (o_busy !== 1'b1 || ov_timeout_cnt !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL to_still_locked: got busy=%b to=%0d, required busy=1 to=0", o_busy, ov_timeout_cnt);
    end
    tick();
    n_checks++;
    if (o_busy !== 1'b0 || ov_timeout_cnt !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL to_release: got busy=%b to=%0d, required busy=0 to=1", o_busy, ov_timeout_cnt);
    end
    serve_flit(0, got, lat, d, a, g, ackv);
    iv_wr[1] = 1'b0;
    n_checks++;
    if (got !== 1'b1 || g !== 3'd1 || d !== mk_flit(2'b11, 1, 16'h0610)) begin
      n_fail++;
      $display("[TB] FAIL to_next_grant: got strobe=%b gid=%0d data=%h, required gid=1 data=%h", got, g, d, mk_flit(2'b11, 1, 16'h0610));
    end
    tick();
  endtask

  task automatic test_nohead();
    logic [1:0]    hdrs [3] = '{2'b00, 2'b00, 2'b10};
    logic          got;
    int            lat;
    logic [FW-1:0] d;
    logic [AW-1:0] a;
    logic [2:0]    g;
    logic [N-1:0]  ackv;
    $display("[TB] packet starting without head bits");
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      set_req(2, 1'b1, hdrs[f], 16'h0700 + 16'(f));
      serve_flit(0, got, lat, d, a, g, ackv);
      n_checks++;
      if (got !== 1'b1 || g !== 3'd2 || d !== mk_flit(hdrs[f], 2, 16'h0700 + 16'(f))) begin
        n_fail++;
        $display("[TB] FAIL nh_flit%0d: got strobe=%b gid=%0d data=%h, required gid=2 data=%h",
                 f, got, g, d, mk_flit(hdrs[f], 2, 16'h0700 + 16'(f)));
      end
    end
    iv_wr[2] = 1'b0;
    tick();
    n_checks++;
    if (ov_nohead_cnt !== 8'd1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL nh_count: got nohead=%0d busy=%b, required nohead=1 busy=0", ov_nohead_cnt, o_busy);
    end
  endtask

  task automatic test_reset_midpacket();
    logic          got;
    logic          seen;
    int            lat;
    logic [FW-1:0] d;
    logic [AW-1:0] a;
    logic [2:0]    g;
    logic [N-1:0]  ackv;
    $display("[TB] reset during WAIT_ACK of the second flit");
    apply_reset();
    set_req(1, 1'b1, 2'b01, 16'h0800);
    serve_flit(0, got, lat, d, a, g, ackv);
    set_req(1, 1'b1, 2'b00, 16'h0801);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (o_data_wr === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b1 || ov_data_waddr !== 16'h0801) begin
      n_fail++;
      $display("[TB] FAIL rm_second_strobe: got strobe=%b addr=%h, required strobe=1 addr=0801", seen, ov_data_waddr);
    end
    i_rst_n = 1'b0;
    #2;
    n_checks++;
    if ({ov_ack, o_data_wr, ov_data_waddr, ov_grant_id, o_busy, ov_timeout_cnt, ov_nohead_cnt} !== '0 || ov_wdata !== '0) begin
      n_fail++;
      $display("[TB] FAIL rm_async_clear: got ack=%b wr=%b addr=%h gid=%0d busy=%b, required all 0",
               ov_ack, o_data_wr, ov_data_waddr, ov_grant_id, o_busy);
    end
    iv_wr = '0;
    tick();
    i_rst_n = 1'b1;
    tick();
    i_wdata_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (ov_ack !== 4'b0000 || o_data_wr !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rm_stray_ack%0d: got ack=%b wr=%b busy=%b, required all 0", c, ov_ack, o_data_wr, o_busy);
      end
    end
    i_wdata_ack = 1'b0;
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_single_packet();
    test_two_requesters();
    test_single_flit();
    test_timeout();
    test_nohead();
    test_reset_midpacket();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
